// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default sizes, parity and vote helpers.
`timescale 1ns/1ps
package uart_pkg;

    localparam int N_BIT_DEF      = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity over a zero-extended word; the transmitter uses the same helper.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus the re-arm tracker that blocks
// a new start until the line has been seen high while idle.
`timescale 1ns/1ps
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic idle,
    input  logic start_go,
    output logic rx_s,
    output logic armed
);

    logic meta_q, meta_d;
    logic rx_s_q, rx_s_d;
    logic armed_q, armed_d;

    always_comb begin
        meta_d  = rx;
        rx_s_d  = meta_q;
        armed_d = armed_q;
        // Arming only while idle keeps a low line after a framing error from retriggering.
        if (start_go)
            armed_d = 1'b0;
        else if (idle && rx_s_q)
            armed_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            rx_s_q  <= rx_s_d;
            armed_q <= armed_d;
        end
    end

    assign rx_s  = rx_s_q;
    assign armed = armed_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, N_BIT data LSB first, even parity, one stop, 16x oversampled.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three ticks.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int N_BIT      = N_BIT_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S_tick,
    input  logic             rx,
    output logic [N_BIT-1:0] dout,
    output logic             rx_done_tick,
    output logic             parity_err,
    output logic             frame_err
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (N_BIT > 1) ? $clog2(N_BIT) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N_BIT - 1);

    uart_state_e      state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [N_BIT-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [N_BIT-1:0] dout_q, dout_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             done_q, done_d;

    logic rx_s, armed, idle, start_go, sample_bit;

    assign idle     = (state_q == ST_IDLE);
    assign start_go = idle && armed && !rx_s;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .idle     (idle),
        .start_go (start_go),
        .rx_s     (rx_s),
        .armed    (armed)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two stored ticks plus the live value form the window at ticks 5, 6, 7 of a bit.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (S_tick)
            hist_d = {hist_q[0], rx_s};
    end

    always_ff @(posedge clk) begin
        if (rst)
            hist_q <= 2'b11;
        else
            hist_q <= hist_d;
    end

    assign sample_bit = maj3({hist_q, rx_s});
`else
    assign sample_bit = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        dout_d  = dout_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (start_go)
                    state_d = ST_START;
            end
            ST_START: begin
                if (S_tick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        bit_d  = '0;
                        state_d = sample_bit ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (S_tick) begin
                    if (tick_q == TICK_LAST) begin
                        shift_d = N_BIT'({sample_bit, shift_q} >> 1);
                        tick_d  = '0;
                        if (bit_q == BIT_LAST)
                            state_d = ST_PARITY;
                        else
                            bit_d = bit_q + BW'(1);
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (S_tick) begin
                    if (tick_q == TICK_LAST) begin
                        par_d   = sample_bit;
                        tick_d  = '0;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (S_tick) begin
                    if (tick_q == TICK_LAST) begin
                        // Leave mid stop bit so a back-to-back start edge is not missed.
                        dout_d  = shift_q;
                        perr_d  = par_q ^ even_parity(32'(shift_q));
                        ferr_d  = ~sample_bit;
                        done_d  = 1'b1;
                        tick_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized frame-level bench for uart_rx: a behavioural line driver plus a queue of expected words.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int NB = 8;
    localparam int OS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_tick = 1'b0;
    logic          rx = 1'b1;
    logic [NB-1:0] dout;
    logic          rx_done_tick, parity_err, frame_err;

    uart_rx #(.N_BIT(NB), .OVERSAMPLE(OS)) dut (
        .clk          (clk),
        .rst          (rst),
        .S_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int div = 0;
    always @(posedge clk) begin
        div    <= (div == 3) ? 0 : div + 1;
        s_tick <= (div == 3);
    end

    int n_chk = 0, n_fail = 0, done_cnt = 0, exp_cnt = 0;
    logic [NB+1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every done cycle is counted, so a stretched pulse shows up as an extra frame.
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            logic [NB+1:0] e;
            done_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dout", 32'(dout), 32'(e[NB+1:2]));
                check("parity_err", 32'(parity_err), 32'(e[1]));
                check("frame_err", 32'(frame_err), 32'(e[0]));
            end
        end
    end

    // Return right after the DUT has consumed one S_tick.
    task automatic wait_tick();
        @(negedge clk);
        while (s_tick !== 1'b1) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        rx = b;
        for (int j = 1; j <= OS; j++) begin
            wait_tick();
            if (glitch && j == 7) rx = ~b;
            if (glitch && j == 8) rx = b;
        end
    endtask

    task automatic send_frame(input logic [NB-1:0] data, input logic par_flip,
                              input logic stop, input logic glitch);
        logic par;
        par = (^data) ^ par_flip;
        exp_q.push_back({data, par_flip, ~stop});
        exp_cnt++;
        send_bit(1'b0, glitch);
        for (int i = 0; i < NB; i++) send_bit(data[i], glitch);
        send_bit(par, glitch);
        send_bit(stop, glitch);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * OS) wait_tick();
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_done", 32'(rx_done_tick), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        rst = 1'b0;
        idle_bits(2);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check("a5_done_cnt", 32'(done_cnt), 32'(exp_cnt));
        idle_bits(1);

        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        check("3c_done_cnt", 32'(done_cnt), 32'(exp_cnt));
        idle_bits(1);

        // Stop bit low, then the line stays low well past the frame.
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) wait_tick();
        idle_bits(2);
        check("ferr_no_retrig", 32'(done_cnt), 32'(exp_cnt));

        // Short low pulse while idle is a false start.
        rx = 1'b0;
        repeat (4) wait_tick();
        idle_bits(2);
        check("false_start_cnt", 32'(done_cnt), 32'(exp_cnt));
        check("false_start_dout", 32'(dout), 32'h81);
        check("false_start_ferr", 32'(frame_err), 32'h1);

        // Reset in the middle of data bit 3 of 0xFF.
        send_bit(1'b0, 1'b0);
        rx = 1'b1;
        repeat (3 * OS + 8) wait_tick();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_dout", 32'(dout), 32'h0);
        check("midrst_ferr", 32'(frame_err), 32'h0);
        idle_bits(1);
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        check("after_rst_cnt", 32'(done_cnt), 32'(exp_cnt));
        idle_bits(1);

        send_frame(8'h00, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        check("b2b_cnt", 32'(done_cnt), 32'(exp_cnt));
        idle_bits(1);

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        check("glitch_cnt", 32'(done_cnt), 32'(exp_cnt));
        idle_bits(1);
`endif

        for (int k = 0; k < 16; k++) begin
            logic [NB-1:0] d;
            logic pf, sb, gl;
            int gap;
            d   = NB'($urandom);
            pf  = ($urandom_range(0, 3) == 0);
            sb  = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_MAJORITY_EN
            gl  = $urandom_range(0, 1) == 1;
`else
            gl  = 1'b0;
`endif
            gap = sb ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send_frame(d, pf, sb, gl);
            check("rand_cnt", 32'(done_cnt), 32'(exp_cnt));
            if (gap > 0) idle_bits(gap);
        end

        idle_bits(1);
        check("final_cnt", 32'(done_cnt), 32'(exp_cnt));
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that recovers `N_BIT`-data-bit UART frames (start, data LSB first, even parity, one stop) from a 16x-oversampled line, using the same `S_tick` baud-tick generator as the transmitter. It is the receive half of the UART link and loops back directly against the transmitter for test. It delivers a parallel word with a one-cycle done pulse, plus per-frame parity and framing error flags.

## Interface
- `N_BIT`, 8: number of data bits per frame.
- `OVERSAMPLE`, 16: `S_tick` pulses per bit period.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset: synchronous and active-high.
- `S_tick`  input  1  one-`clk` pulse at 16x baud rate.
- `rx`  input  1  asynchronous serial line; idle high.
- `dout`  output  `N_BIT`  received data word.
- `rx_done_tick`  output  1  one-cycle pulse when a frame completes.
- `parity_err`  output  1  received parity bit does not equal `^dout`.
- `frame_err`  output  1  stop bit sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer (flops reset to 1). All FSM decisions use the synchronized value `rx_s`.
- FSM states:
  - IDLE
    - Clear the tick and bit counters.
    - If `armed` and `rx_s==0`, go to START.
    - `armed` sets when `rx_s==1` and clears on entering START.
  - START
    - Count `S_tick`.
    - At tick 7 (mid start bit), sample.
    - Sample 1 means a false start: go to IDLE, with no outputs changed.
    - Sample 0: go to DATA with tick=0, bit=0.
  - DATA
    - On the `S_tick` where tick==15, take a sample and shift it into the MSB of the shift register (right-shift, LSB arrives first), then bit++ and tick=0.
    - After bit `N_BIT-1`, go to PARITY.
  - PARITY: at tick 15, sample the parity bit and go to STOP.
  - STOP
    - At tick 15, sample the stop bit.
    - Load `dout` from the shift register.
    - `parity_err` = parity sample XOR (^data).
    - `frame_err` = ~stop sample.
    - Pulse `rx_done_tick` and go to IDLE.
- Tick counter: 4 bits, wraps 15→0; it advances only on `S_tick`.
- `dout`, `parity_err` and `frame_err` hold their values until the next completed frame. A false start does not alter them.
- After a frame error the line may still be low. `armed` prevents re-triggering until `rx_s` returns high.
- `rst` at any point, including mid-frame, aborts the frame and returns the block to IDLE.

## Timing
- Reset values:
  - `dout`=0, `rx_done_tick`=0, `parity_err`=0, `frame_err`=0.
  - State IDLE, counters 0, `armed`=0, synchronizer flops=1.
- Input latency: 2 `clk` through the synchronizer, plus up to 1 `S_tick` period of edge uncertainty.
- `rx_done_tick` is registered. It is high for exactly one `clk`, in the cycle after the `S_tick` that samples the stop bit. `dout` and the error flags are valid in that same cycle.
- Each sample point is 7 ticks into its bit (start) and 16 ticks after the previous sample point (all later bits).
- The FSM returns to IDLE mid stop bit, so a back-to-back frame whose start edge follows the stop bit is captured.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - A 3-bit history records `rx_s` on every `S_tick`.
  - Each sample (start check, data, parity, stop) is the 2-of-3 majority of the values recorded at ticks 5, 6 and 7 of that bit.
  - A single-tick glitch at the sample point is rejected.
- `UART_RX_MAJORITY_EN` undefined: each sample is the single value of `rx_s` at the sample-point tick. The history register is not built.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding constants: IDLE, START, DATA, PARITY, STOP (3-bit).
  - `N_BIT` and `OVERSAMPLE` defaults.
  - Parity function (even, `^data`) shared with the transmitter.
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer plus the `armed` tracking, with output `rx_s`.

## Test plan
- Frame 0xA5, parity 0, stop 1 → `dout`=0xA5, one `rx_done_tick`, `parity_err`=0, `frame_err`=0.
- Frame 0x3C with parity bit 1 (correct is 0) → `dout`=0x3C, `parity_err`=1, `frame_err`=0.
- Frame 0x81 with stop bit 0 → `frame_err`=1. Line held low 40 ticks, then high → no second `rx_done_tick` until a new start edge.
- 4-tick low pulse while idle → no `rx_done_tick`, `dout` unchanged, FSM back in IDLE.
- Assert `rst` during data bit 3 of 0xFF, then send 0x12 → only 0x12 is reported, with no errors.
- Loopback against the transmitter, 0x00 then 0xFF back-to-back → two done pulses with `dout` 0x00 then 0xFF. With `UART_RX_MAJORITY_EN` defined, a 1-tick inverted glitch at each data sample point still yields the correct data.
